// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU adder/subtractor datapaths.
//   ALU_WIDTH   - default operand width of the ALU datapaths
//   alu_flags_t - result flag vector, MSB..LSB = {bout, ovf, zero, neg}
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef struct packed {
    logic bout;
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

endpackage

// File: rtl/cla_slice.sv
// cla_slice: purely combinational N-bit carry-lookahead adder slice.
// Ports:
//   a, b  [N] - addends
//   cin       - carry in
//   s     [N] - sum, modulo 2^N
//   cout      - carry out of the top bit
module cla_slice #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         run;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is built as a flat sum of products
  //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  // so no carry depends on the carry below it.
  always_comb begin
    c    = '0;
    run  = 1'b1;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      run      = 1'b1;
      c[i + 1] = 1'b0;
      for (int j = i; j >= 0; j--) begin
        c[i + 1] = c[i + 1] | (run & g[j]);
        run      = run & p[j];
      end
      c[i + 1] = c[i + 1] | (run & cin);
    end
  end

  assign s    = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/pipe_cla_subtractor.sv
// pipe_cla_subtractor: two-stage pipelined signed subtractor,
// Diff = A - B - Bin evaluated as A + ~B + ~Bin on two lookahead slices.
// Stage 1 computes the low SPLIT bits and registers the slice carry;
// stage 2 computes the upper bits and the flags. Outputs come straight
// from stage-2 registers.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - operand handshake (A, B, Bin)
//   out_valid, out_ready- result handshake (Diff, Bout, Ovf, Zero, Neg)
//   Bout = 1 iff unsigned A < B + Bin; Ovf = signed overflow
module pipe_cla_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SPLIT = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero,
  output logic             Neg
);

  localparam int HI = WIDTH - SPLIT;

  logic             adv1;
  logic             adv2;

  logic [WIDTH-1:0] b_n;
  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;

  logic             s1_valid;
  logic [SPLIT-1:0] s1_lo;
  logic             s1_cmid;
  logic [HI-1:0]    s1_ahi;
  logic [HI-1:0]    s1_bnhi;
  logic             s1_amsb;
  logic             s1_bmsb;

  logic [HI-1:0]    hi_sum;
  logic             hi_cout;
  logic [WIDTH-1:0] diff_next;
  alu_flags_t       flags_next;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_diff;
  alu_flags_t       s2_flags;

  // A stage may load when it is empty or its contents leave this cycle.
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  assign b_n = ~B;

  // Subtraction as addition of the complement; a borrow-in of 1 means
  // no +1 from the two's-complement carry.
  cla_slice #(.N(SPLIT)) u_lo (
    .a    (A[SPLIT-1:0]),
    .b    (b_n[SPLIT-1:0]),
    .cin  (~Bin),
    .s    (lo_sum),
    .cout (lo_cout)
  );

  // Stage 1 valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
    end
  end

  // Stage 1 data: only loaded on a real input transfer.
  always_ff @(posedge clk) begin
    if (!rst && adv1 && in_valid) begin
      s1_lo   <= lo_sum;
      s1_cmid <= lo_cout;
      s1_ahi  <= A[WIDTH-1:SPLIT];
      s1_bnhi <= b_n[WIDTH-1:SPLIT];
      s1_amsb <= A[WIDTH-1];
      s1_bmsb <= B[WIDTH-1];
    end
  end

  cla_slice #(.N(HI)) u_hi (
    .a    (s1_ahi),
    .b    (s1_bnhi),
    .cin  (s1_cmid),
    .s    (hi_sum),
    .cout (hi_cout)
  );

  // Borrow is the inverted carry; overflow only possible when the
  // operand signs differ.
  always_comb begin
    diff_next       = {hi_sum, s1_lo};
    flags_next.bout = ~hi_cout;
    flags_next.ovf  = (s1_amsb != s1_bmsb) && (diff_next[WIDTH-1] != s1_amsb);
    flags_next.zero = (diff_next == '0);
    flags_next.neg  = diff_next[WIDTH-1];
  end

  // Stage 2 is reset fully so every output reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_diff  <= '0;
      s2_flags <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_diff  <= diff_next;
        s2_flags <= flags_next;
      end
    end
  end

  assign out_valid = s2_valid;
  assign Diff      = s2_diff;
  assign Bout      = s2_flags.bout;
  assign Ovf       = s2_flags.ovf;
  assign Zero      = s2_flags.zero;
  assign Neg       = s2_flags.neg;

endmodule

// File: tb/tb_pipe_cla_subtractor.sv
// tb_pipe_cla_subtractor: self-checking bench for pipe_cla_subtractor.
// A queue-based reference model predicts every result and the handshake
// behaviour from plain arithmetic; directed cases pin literal values.
module tb_pipe_cla_subtractor;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -MAXS - 64'sd1;

  typedef struct packed {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  typedef struct {
    res_t r;
    int   stamp;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Diff;
  logic        Bout;
  logic        Ovf;
  logic        Zero;
  logic        Neg;

  int     errors = 0;
  int     checks = 0;
  int     emitted = 0;
  int     edgeNo = 0;
  logic   prevRst = 1'b0;
  entry_t q[$];

  pipe_cla_subtractor #(.WIDTH(32), .SPLIT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout),
    .Ovf       (Ovf),
    .Zero      (Zero),
    .Neg       (Neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer subtraction, flags from their definitions.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    res_t        r;
    logic [32:0] wide;
    longint      sd;
    wide   = {1'b0, a} - {1'b0, b} - {32'b0, bin};
    r.diff = wide[31:0];
    r.bout = ({1'b0, a} < ({1'b0, b} + {32'b0, bin}));
    sd     = longint'($signed(a)) - longint'($signed(b)) - longint'({31'b0, bin});
    r.ovf  = (sd > MAXS) || (sd < MINS);
    r.zero = (r.diff == 32'd0);
    r.neg  = r.diff[31];
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corner [7];
    corner = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000,
               32'hFFFFFFFF, 32'h0000FFFF, 32'h00010000};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 6)];
    return $urandom();
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one operand at a negedge and hold it until it is accepted.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic bin);
    int waitCnt;
    @(negedge clk);
    A = a;
    B = b;
    Bin = bin;
    in_valid = 1'b1;
    #1;
    waitCnt = 0;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    if (!in_ready) checkOutput("accept_timeout", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string name, input res_t exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!out_valid && n < 20);
    checkOutput(name, {27'b0, out_valid, Diff, Bout, Ovf, Zero, Neg}, {27'b0, 1'b1, exp});
  endtask

  // Compare process: observes every cycle after inputs settle, checks
  // the DUT against the queue model, then records transfers for the
  // upcoming edge.
  initial begin
    logic expValid;
    forever begin
      @(negedge clk);
      #2;
      if (prevRst) begin
        checkOutput("reset_outputs", {27'b0, out_valid, Diff, Bout, Ovf, Zero, Neg}, 64'd0);
      end
      if (rst) begin
        q.delete();
        prevRst = 1'b1;
      end else begin
        prevRst  = 1'b0;
        expValid = (q.size() > 0) && (q[0].stamp + 1 < edgeNo);
        checkOutput("out_valid", {63'b0, out_valid}, {63'b0, expValid});
        checkOutput("in_ready", {63'b0, in_ready}, {63'b0, (q.size() < 2) || out_ready});
        if (out_valid && expValid) begin
          checkOutput("result", {28'b0, Diff, Bout, Ovf, Zero, Neg}, {28'b0, q[0].r});
        end
        if (out_valid && out_ready) begin
          emitted++;
          if (q.size() > 0) void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          q.push_back('{r: model(A, B, Bin), stamp: edgeNo});
        end
      end
      edgeNo++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] bpA [5];
    logic [31:0] bpB [5];
    logic        bpBin [5];
    res_t        bpExp [5];
    int          n;
    int          emittedBefore;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    Bin = 1'b0;

    // Literal pins on the model itself.
    checkOutput("model_5_3", {28'b0, model(32'd5, 32'd3, 1'b0)}, {28'b0, 32'd2, 4'b0000});
    checkOutput("model_0_1", {28'b0, model(32'd0, 32'd1, 1'b0)}, {28'b0, 32'hFFFFFFFF, 4'b1001});
    checkOutput("model_ovf", {28'b0, model(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0)},
                {28'b0, 32'h80000000, 4'b1101});

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases with literal expectations.
    applyStimulus(32'd5, 32'd3, 1'b0);
    waitResult("basic", {32'd2, 4'b0000});
    applyStimulus(32'd0, 32'd1, 1'b0);
    waitResult("borrow_neg", {32'hFFFFFFFF, 4'b1001});
    applyStimulus(32'h00010000, 32'd0, 1'b1);
    waitResult("cross_slice", {32'h0000FFFF, 4'b0000});
    applyStimulus(32'd7, 32'd7, 1'b0);
    waitResult("zero", {32'd0, 4'b0010});
    applyStimulus(32'h80000000, 32'd1, 1'b0);
    waitResult("ovf_neg_min", {32'h7FFFFFFF, 4'b0100});
    applyStimulus(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
    waitResult("ovf_pos_max", {32'h80000000, 4'b1101});

    // Back-pressure: five operands streamed against a stalled consumer.
    for (int k = 0; k < 5; k++) begin
      bpA[k]   = $urandom();
      bpB[k]   = $urandom();
      bpBin[k] = 1'($urandom_range(0, 1));
      bpExp[k] = model(bpA[k], bpB[k], bpBin[k]);
    end
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) applyStimulus(bpA[k], bpB[k], bpBin[k]);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          #3;
          n++;
        end while (!out_valid && n < 30);
        checkOutput("bp_first_valid", {63'b0, out_valid}, 64'd1);
        checkOutput("bp_in_ready_full", {63'b0, in_ready}, 64'd0);
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          #3;
          checkOutput("bp_hold", {31'b0, out_valid, Diff}, {31'b0, 1'b1, bpExp[0].diff});
          checkOutput("bp_hold_ready", {63'b0, in_ready}, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #3;
        for (int k = 0; k < 5; k++) begin
          if (k > 0) begin
            @(negedge clk);
            #3;
          end
          checkOutput("bp_stream", {27'b0, out_valid, Diff, Bout, Ovf, Zero, Neg},
                      {27'b0, 1'b1, bpExp[k]});
        end
      end
    join

    // Reset with two operations in flight.
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(32'd100, 32'd1, 1'b0);
    applyStimulus(32'd200, 32'd2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    A = 32'd9;
    B = 32'd4;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #3;
    checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd1);
    emittedBefore = emitted;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #3;
    checkOutput("rst_no_emit", 64'(emitted), 64'(emittedBefore));

    // Randomized traffic with random back-pressure and rare resets.
    repeat (400) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      A   = pick();
      B   = pick();
      Bin = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    checkOutput("drain_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
